imm_encoder: RTL and testbench

- Inverse of the core's immediate decoder: packs opcode, register fields, funct3 and a 32-bit immediate into a 32-bit RV32I instruction word.
- Formats encoded: I-load, I-ALU, S-store, U-AUIPC.
- Registered, valid/ready streaming stage with a running word address, so test programs and boot images can be written straight into instruction memory.
- Illegal requests are dropped and counted.

---
 rtl/imm_encoder.sv | 235 +++++++++++++++++++++++
 tb/tb_imm_encoder.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_encoder.sv
// imm_encoder: builds RV32I instruction words for the load, ALU-immediate,
// store and AUIPC formats. Each word leaves through a one-entry registered
// output together with its byte address, so a stream of requests can be
// written straight into instruction memory.
//
// Ports
//   clk, reset   rising-edge clock, synchronous active-high reset
//   clear        restarts the address and word counters; a held word is kept
//   in_*         request: opcode, rd, rs1, rs2, funct3 and a 32-bit immediate
//   in_ready     request taken when in_valid && in_ready
//   out_valid    encoded word held in the output register
//   out_ready    consumer takes the word when out_valid && out_ready
//   out_data     encoded instruction
//   out_addr     byte address of out_data
//   err_pulse    high for one cycle after an illegal request is consumed
//   err_count    saturating count of illegal requests
//   word_count   saturating count of words delivered since reset/clear
//   dbg_state    current FSM state (0 = EMPTY, 1 = FULL)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A producer holding valid keeps its payload stable until that
// edge; ready may depend combinationally on the downstream ready.
module imm_encoder #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_pulse,
  output logic [7:0]        err_count,
  output logic [15:0]       word_count,
  output logic              dbg_state
);

  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_ALUI   = 7'b0010011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
  localparam logic [31:0] LAST_SLOT = 32'(MAX_WORDS - 1);
  localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(4);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t state_q;
  state_t state_d;

  logic [31:0]       enc_word;
  logic              enc_legal;
  logic              imm_fits12;
  logic              accept;
  logic              load;
  logic              xfer;
  logic              illegal;

  // Address that the next loaded word will receive, and its position
  // within the MAX_WORDS window (used to decide when to wrap).
  logic [ADDR_W-1:0] next_addr_q;
  logic [31:0]       slot_q;
  logic [ADDR_W-1:0] load_addr;
  logic [31:0]       load_slot;

  // ---------------------------------------------------------------------
  // Encoder and legality check
  // ---------------------------------------------------------------------
  // A 12-bit signed immediate is representable when bits 31..11 are all
  // copies of the sign bit.
  assign imm_fits12 = (in_imm[31:11] == '0) || (in_imm[31:11] == '1);

  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b0;
    case (in_opcode)
      OP_LOAD, OP_ALUI: begin
        enc_word  = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        enc_legal = imm_fits12;
      end
      OP_STORE: begin
        enc_word  = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        enc_legal = imm_fits12;
      end
      OP_AUIPC: begin
        // The low 12 bits cannot be represented, so they must be zero.
        enc_word  = {in_imm[31:12], in_rd, in_opcode};
        enc_legal = (in_imm[11:0] == '0);
      end
      default: begin
        enc_word  = '0;
        enc_legal = 1'b0;
      end
    endcase
  end

  assign accept  = in_valid && in_ready;
  assign load    = accept && enc_legal;
  assign illegal = accept && !enc_legal;
  assign xfer    = out_valid && out_ready;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: begin
        if (load) state_d = FULL;
      end
      FULL: begin
        // A new legal word refills the slot in the same cycle the old one
        // leaves, which is what keeps throughput at one word per cycle.
        if (load)      state_d = FULL;
        else if (xfer) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  always_comb begin
    out_valid = 1'b0;
    in_ready  = 1'b0;
    dbg_state = 1'b0;
    case (state_q)
      EMPTY: begin
        out_valid = 1'b0;
        in_ready  = 1'b1;
        dbg_state = 1'b0;
      end
      FULL: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        dbg_state = 1'b1;
      end
      default: begin
        out_valid = 1'b0;
        in_ready  = 1'b0;
        dbg_state = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Address assignment
  // ---------------------------------------------------------------------
  // A word loaded in the same cycle as clear is the first word of the new
  // sequence, so it takes BASE_ADDR directly.
  assign load_addr = clear ? BASE_ADDR : next_addr_q;
  assign load_slot = clear ? '0 : slot_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      next_addr_q <= BASE_ADDR;
      slot_q      <= '0;
    end else if (load) begin
      if (load_slot == LAST_SLOT) begin
        next_addr_q <= BASE_ADDR;
        slot_q      <= '0;
      end else begin
        next_addr_q <= load_addr + WORD_BYTES;
        slot_q      <= load_slot + 32'd1;
      end
    end else if (clear) begin
      next_addr_q <= BASE_ADDR;
      slot_q      <= '0;
    end
  end

  // ---------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------
  // Only a legal accept touches the held word; illegal requests and clear
  // leave data and address alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data <= '0;
      out_addr <= BASE_ADDR;
    end else if (load) begin
      out_data <= enc_word;
      out_addr <= load_addr;
    end
  end

  // ---------------------------------------------------------------------
  // Error and word counters
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      err_pulse <= illegal;
      if (illegal && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

  // clear takes priority over a coinciding transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_count <= '0;
    end else if (clear) begin
      word_count <= '0;
    end else if (xfer && (word_count != 16'hFFFF)) begin
      word_count <= word_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
module tb_imm_encoder;

  localparam int          ADDR_W = 32;
  localparam logic [31:0] BASE   = 32'h0000_0000;
  localparam int          MAXW   = 4;

  // ---------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------
  logic              clk = 1'b0;
  logic              reset;
  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic [6:0]        in_opcode;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_funct3;
  logic [31:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              err_pulse;
  logic [7:0]        err_count;
  logic [15:0]       word_count;
  logic              dbg_state;

  always #5 clk = ~clk;

  imm_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr),
    .err_pulse(err_pulse), .err_count(err_count), .word_count(word_count),
    .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // ---------------------------------------------------------------------
  // Reference model / scoreboard
  // ---------------------------------------------------------------------
  logic [31:0]       exp_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];
  int                m_words;
  int                m_wc;
  int                m_err;
  logic              m_err_pulse;
  logic              m_rdy;
  logic              m_xfer;
  logic [31:0]       xfer_data;
  logic [ADDR_W-1:0] xfer_addr;

  // Instruction encoding from the RV32I field layout; legality from the
  // numeric range of the immediate.
  function automatic logic ref_encode(input logic [6:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic [2:0] f3, input logic [31:0] imm,
                                      output logic [31:0] word);
    int  simm;
    logic ok;
    simm = int'($signed(imm));
    word = '0;
    ok   = 1'b0;
    case (op)
      7'b0000011, 7'b0010011: begin
        word = {imm[11:0], rs1, f3, rd, op};
        ok   = (simm >= -2048) && (simm <= 2047);
      end
      7'b0100011: begin
        word = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
        ok   = (simm >= -2048) && (simm <= 2047);
      end
      7'b0010111: begin
        word = {imm[31:12], rd, op};
        ok   = ((imm % 32'd4096) == 32'd0);
      end
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    exp_addr_q.delete();
    m_words     = 0;
    m_wc        = 0;
    m_err       = 0;
    m_err_pulse = 1'b0;
  endtask

  // Advance the model over the coming clock edge using the current inputs.
  task automatic model_step();
    logic        legal;
    logic [31:0] w;
    m_rdy  = (exp_q.size() == 0) || out_ready;
    m_xfer = (exp_q.size() != 0) && out_ready;
    if (m_xfer) begin
      xfer_data = exp_q.pop_front();
      xfer_addr = exp_addr_q.pop_front();
      if (m_wc < 65535) m_wc++;
    end
    if (clear) begin
      m_wc    = 0;
      m_words = 0;
    end
    legal = ref_encode(in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_imm, w);
    m_err_pulse = in_valid && m_rdy && !legal;
    if (m_err_pulse && m_err < 255) m_err++;
    if (in_valid && m_rdy && legal) begin
      exp_q.push_back(w);
      exp_addr_q.push_back(BASE + ADDR_W'(4 * (m_words % MAXW)));
      m_words++;
    end
  endtask

  // ---------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------
  task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [31:0] imm, input logic ordy, input logic clr);
    in_valid  = v;
    in_opcode = op;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_funct3 = f3;
    in_imm    = imm;
    out_ready = ordy;
    clear     = clr;
    #1;
  endtask

  task automatic idle(input logic ordy, input logic clr);
    drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0, ordy, clr);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    model_reset();
  endtask

  // ---------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'd0 || out_addr !== BASE) begin
      errors++;
      $display("FAIL reset_out valid=%b data=%h addr=%h required 0 00000000 %h", out_valid, out_data, out_addr, BASE);
    end
    checks++;
    if (err_pulse !== 1'b0 || err_count !== 8'd0 || word_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_counters pulse=%b err=%0d wc=%0d required 0 0 0", err_pulse, err_count, word_count);
    end
    checks++;
    if (in_ready !== 1'b1 || dbg_state !== 1'b0) begin
      errors++;
      $display("FAIL reset_state in_ready=%b state=%b required 1 0", in_ready, dbg_state);
    end
  endtask

  task automatic test_alu();
    do_reset();
    drive(1'b1, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    model_step();
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hFFF1_0093 || out_addr !== 32'd0) begin
      errors++;
      $display("FAIL addi valid=%b data=%h addr=%h required 1 fff10093 00000000", out_valid, out_data, out_addr);
    end
    idle(1'b1, 1'b0);
    model_step();
    tick();
    checks++;
    if (out_valid !== 1'b0 || word_count !== 16'd1) begin
      errors++;
      $display("FAIL addi_drain valid=%b wc=%0d required 0 1", out_valid, word_count);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1'b1, 7'b0100011, 5'd0, 5'd6, 5'd5, 3'd2, 32'd8, 1'b1, 1'b0);
    model_step();
    tick();
    checks++;
    if (out_data !== 32'h0053_2423 || out_addr !== 32'd0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL sw data=%h addr=%h valid=%b required 00532423 00000000 1", out_data, out_addr, out_valid);
    end
    drive(1'b1, 7'b0010111, 5'd3, 5'd0, 5'd0, 3'd0, 32'h1234_5000, 1'b1, 1'b0);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready in_ready=%b required 1", in_ready);
    end
    model_step();
    tick();
    checks++;
    if (out_data !== 32'h1234_5197 || out_addr !== 32'd4 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL auipc data=%h addr=%h valid=%b required 12345197 00000004 1", out_data, out_addr, out_valid);
    end
    idle(1'b1, 1'b0);
    model_step();
    tick();
    checks++;
    if (out_valid !== 1'b0 || word_count !== 16'd2) begin
      errors++;
      $display("FAIL b2b_drain valid=%b wc=%0d required 0 2", out_valid, word_count);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] hold_data;
    do_reset();
    drive(1'b1, 7'b0000011, 5'd7, 5'd9, 5'd0, 3'd2, 32'h0000_07FF, 1'b0, 1'b0);
    model_step();
    tick();
    hold_data = exp_q[0];
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 7'b0010011, 5'd4, 5'd4, 5'd0, 3'd0, 32'd5, 1'b0, 1'b0);
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_ready cycle=%0d in_ready=%b required 0", i, in_ready);
      end
      model_step();
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== hold_data || out_addr !== 32'd0) begin
        errors++;
        $display("FAIL bp_hold cycle=%0d valid=%b data=%h addr=%h required 1 %h 00000000", i, out_valid, out_data, out_addr, hold_data);
      end
    end
    idle(1'b1, 1'b0);
    model_step();
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || word_count !== 16'd1) begin
      errors++;
      $display("FAIL bp_release valid=%b in_ready=%b wc=%0d required 0 1 1", out_valid, in_ready, word_count);
    end
  endtask

  task automatic test_illegal();
    logic [6:0]  ops[3]  = '{7'b0010011, 7'b0010111, 7'b0110011};
    logic [31:0] imms[3] = '{32'd2048, 32'h0000_0001, 32'd0};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, ops[i], 5'd1, 5'd1, 5'd1, 3'd0, imms[i], 1'b1, 1'b0);
      model_step();
      tick();
      checks++;
      if (err_pulse !== 1'b1 || out_valid !== 1'b0 || err_count !== 8'(i + 1)) begin
        errors++;
        $display("FAIL illegal_%0d pulse=%b valid=%b err=%0d required 1 0 %0d", i, err_pulse, out_valid, err_count, i + 1);
      end
    end
    idle(1'b1, 1'b0);
    model_step();
    tick();
    checks++;
    if (err_pulse !== 1'b0 || err_count !== 8'd3 || out_addr !== BASE) begin
      errors++;
      $display("FAIL illegal_after pulse=%b err=%0d addr=%h required 0 3 %h", err_pulse, err_count, out_addr, BASE);
    end
    drive(1'b1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd1, 1'b1, 1'b0);
    model_step();
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_addr !== BASE || out_data !== 32'h0010_0093) begin
      errors++;
      $display("FAIL illegal_next valid=%b addr=%h data=%h required 1 %h 00100093", out_valid, out_addr, out_data, BASE);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] addrs[5] = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 7'b0010011, 5'(i), 5'd3, 5'd0, 3'd0, 32'(i), 1'b1, 1'b0);
      model_step();
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_addr !== addrs[i]) begin
        errors++;
        $display("FAIL wrap_%0d valid=%b addr=%h required 1 %h", i, out_valid, out_addr, addrs[i]);
      end
    end
    idle(1'b1, 1'b0);
    model_step();
    tick();
    checks++;
    if (word_count !== 16'd5) begin
      errors++;
      $display("FAIL wrap_count wc=%0d required 5", word_count);
    end
  endtask

  task automatic test_clear();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 7'b0010011, 5'd2, 5'd2, 5'd0, 3'd1, 32'(i + 10), 1'b1, 1'b0);
      model_step();
      tick();
    end
    idle(1'b0, 1'b1);
    model_step();
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_addr !== 32'd8 || word_count !== 16'd0) begin
      errors++;
      $display("FAIL clear_hold valid=%b addr=%h wc=%0d required 1 00000008 0", out_valid, out_addr, word_count);
    end
    drive(1'b1, 7'b0000011, 5'd8, 5'd9, 5'd0, 3'd0, 32'hFFFF_F800, 1'b1, 1'b0);
    checks++;
    if (out_addr !== 32'd8 || out_data !== xfer_data_peek()) begin
      errors++;
      $display("FAIL clear_deliver addr=%h data=%h required 00000008 %h", out_addr, out_data, xfer_data_peek());
    end
    model_step();
    tick();
    checks++;
    if (out_addr !== 32'd0 || word_count !== 16'd1 || out_data !== 32'h8004_8403) begin
      errors++;
      $display("FAIL clear_next addr=%h wc=%0d data=%h required 00000000 1 80048403", out_addr, word_count, out_data);
    end
    // clear together with a transfer: the count must end at zero
    idle(1'b1, 1'b1);
    model_step();
    tick();
    checks++;
    if (word_count !== 16'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL clear_xfer wc=%0d valid=%b required 0 0", word_count, out_valid);
    end
  endtask

  function automatic logic [31:0] xfer_data_peek();
    return (exp_q.size() != 0) ? exp_q[0] : 32'hDEAD_BEEF;
  endfunction

  task automatic test_reset_mid();
    do_reset();
    drive(1'b1, 7'b0010011, 5'd5, 5'd5, 5'd0, 3'd0, 32'd3, 1'b0, 1'b0);
    model_step();
    tick();
    reset = 1'b1;
    idle(1'b1, 1'b0);
    tick();
    reset = 1'b0;
    model_reset();
    idle(1'b0, 1'b0);
    tick();
    checks++;
    if (out_valid !== 1'b0 || word_count !== 16'd0 || out_addr !== BASE) begin
      errors++;
      $display("FAIL reset_mid valid=%b wc=%0d addr=%h required 0 0 %h", out_valid, word_count, out_addr, BASE);
    end
  endtask

  task automatic test_random();
    logic [6:0]  op_tab[5] = '{7'b0000011, 7'b0010011, 7'b0100011, 7'b0010111, 7'b0110011};
    logic [31:0] edge_tab[4] = '{32'd2047, 32'hFFFF_F800, 32'd2048, 32'hFFFF_F7FF};
    logic [31:0] imm;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      case ($urandom_range(0, 3))
        0: imm = 32'($signed(12'($urandom)));
        1: imm = $urandom;
        2: imm = {20'($urandom), 12'd0};
        default: imm = edge_tab[$urandom_range(0, 3)];
      endcase
      drive(1'($urandom_range(0, 3) != 0), op_tab[$urandom_range(0, 4)],
            5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), imm,
            1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 49) == 0));
      model_step();
      checks++;
      if (in_ready !== m_rdy) begin
        errors++;
        $display("FAIL rnd_ready cycle=%0d in_ready=%b required %b", c, in_ready, m_rdy);
      end
      if (m_xfer) begin
        checks++;
        if (out_data !== xfer_data || out_addr !== xfer_addr) begin
          errors++;
          $display("FAIL rnd_xfer cycle=%0d data=%h addr=%h required %h %h", c, out_data, out_addr, xfer_data, xfer_addr);
        end
      end
      tick();
      checks++;
      if (out_valid !== (exp_q.size() != 0) || dbg_state !== (exp_q.size() != 0) ||
          err_pulse !== m_err_pulse || err_count !== 8'(m_err) || word_count !== 16'(m_wc)) begin
        errors++;
        $display("FAIL rnd_state cycle=%0d valid=%b state=%b pulse=%b err=%0d wc=%0d required %b %b %b %0d %0d",
                 c, out_valid, dbg_state, err_pulse, err_count, word_count,
                 exp_q.size() != 0, exp_q.size() != 0, m_err_pulse, m_err, m_wc);
      end
    end
  endtask

  // ---------------------------------------------------------------------
  // Sequence and final report
  // ---------------------------------------------------------------------
  initial begin
    reset = 1'b1;
    idle(1'b0, 1'b0);
    test_reset();
    test_alu();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    test_wrap();
    test_clear();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
